// File: rtl/sram_lvt_multiport_if.sv
// Bus bundle for the LVT multi-port register file: write ports, read ports and the ready flag.
interface sram_lvt_multiport_if #(
    parameter int R_PORTS = 2,
    parameter int W_PORTS = 2,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [W_PORTS-1:0] i_w_e;
    logic [AW-1:0]      i_w_addr [0:W_PORTS-1];
    logic [WIDTH-1:0]   i_w_data [0:W_PORTS-1];
    logic [R_PORTS-1:0] i_r_e;
    logic [AW-1:0]      i_r_addr [0:R_PORTS-1];
    logic [WIDTH-1:0]   o_r_data [0:R_PORTS-1];
    logic               o_ready;

    modport master (
        output i_w_e, i_w_addr, i_w_data, i_r_e, i_r_addr,
        input  o_r_data, o_ready
    );

    modport slave (
        input  i_w_e, i_w_addr, i_w_data, i_r_e, i_r_addr,
        output o_r_data, o_ready
    );
endinterface

// File: rtl/sram_lvt_multiport.sv
// Multi-read/multi-write register file: one bank per write port plus a live-value
// table (LVT) naming the bank that holds the newest value of each entry.
// After reset an optional sweep zeroes bank 0 and the LVT before traffic is accepted.
module sram_lvt_multiport #(
    parameter int R_PORTS        = 2,
    parameter int W_PORTS        = 2,
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 8,
    parameter int BYPASS         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    sram_lvt_multiport_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (W_PORTS > 1) ? $clog2(W_PORTS) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_INIT  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_INIT;

    // Entry addresses beyond DEPTH-1 are out of range (DEPTH need not be a power of two).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    logic [1:0]       state_r;
    logic [AW-1:0]    clr_cnt_r;
    logic             ready_r;
    logic [WIDTH-1:0] bank_r   [W_PORTS][DEPTH];
    logic [LW-1:0]    lvt_r    [DEPTH];
    logic [W_PORTS-1:0] w_win_s;
    logic [WIDTH-1:0] rd_val_s [R_PORTS];
    logic [WIDTH-1:0] r_data_r [R_PORTS];

    // Write arbitration: a port writes only if valid and no higher-index port targets the same entry.
    always_comb begin
        w_win_s = '0;
        for (int w = 0; w < W_PORTS; w++) begin
            if (ready_r && bus.i_w_e[w] && addr_ok(bus.i_w_addr[w])) begin
                w_win_s[w] = 1'b1;
                for (int h = w + 1; h < W_PORTS; h++) begin
                    if (bus.i_w_e[h] && (bus.i_w_addr[h] == bus.i_w_addr[w])) begin
                        w_win_s[w] = 1'b0;
                    end else begin
                        w_win_s[w] = w_win_s[w];
                    end
                end
            end else begin
                w_win_s[w] = 1'b0;
            end
        end
    end

    // Read lookup: LVT selects the bank; optional forwarding of the winning same-cycle write.
    always_comb begin
        for (int r = 0; r < R_PORTS; r++) begin
            rd_val_s[r] = '0;
            if (addr_ok(bus.i_r_addr[r])) begin
                for (int w = 0; w < W_PORTS; w++) begin
                    if (lvt_r[bus.i_r_addr[r]] == LW'(w)) begin
                        rd_val_s[r] = bank_r[w][bus.i_r_addr[r]];
                    end else begin
                        rd_val_s[r] = rd_val_s[r];
                    end
                end
                if (BYPASS != 0) begin
                    for (int w = 0; w < W_PORTS; w++) begin
                        if (w_win_s[w] && (bus.i_w_addr[w] == bus.i_r_addr[r])) begin
                            rd_val_s[r] = bus.i_w_data[w];
                        end else begin
                            rd_val_s[r] = rd_val_s[r];
                        end
                    end
                end else begin
                    rd_val_s[r] = rd_val_s[r];
                end
            end else begin
                rd_val_s[r] = '0;
            end
        end
    end

    // Bank and LVT storage: the clear sweep owns bank 0 and the LVT, otherwise winners write.
    always_ff @(posedge i_clk) begin
        if (state_r == ST_CLEAR) begin
            bank_r[0][clr_cnt_r] <= '0;
            lvt_r[clr_cnt_r]     <= '0;
        end else begin
            for (int w = 0; w < W_PORTS; w++) begin
                if (w_win_s[w]) begin
                    bank_r[w][bus.i_w_addr[w]] <= bus.i_w_data[w];
                    lvt_r[bus.i_w_addr[w]]     <= LW'(w);
                end
            end
        end
    end

    // Start-up sequencer: CLEAR sweeps one entry per cycle, INIT waits one cycle, READY is terminal.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_RESET;
            clr_cnt_r <= '0;
            ready_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == AW'(DEPTH - 1)) begin
                        state_r   <= ST_READY;
                        ready_r   <= 1'b1;
                        clr_cnt_r <= '0;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + AW'(1);
                    end
                end
                ST_INIT: begin
                    state_r <= ST_READY;
                    ready_r <= 1'b1;
                end
                ST_READY: begin
                    state_r <= ST_READY;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r   <= ST_RESET;
                    clr_cnt_r <= '0;
                    ready_r   <= 1'b0;
                end
            endcase
        end
    end

    // Registered read data: zero until ready, then updated per enabled port and held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < R_PORTS; r++) begin
                r_data_r[r] <= '0;
            end
        end else if (!ready_r) begin
            for (int r = 0; r < R_PORTS; r++) begin
                r_data_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < R_PORTS; r++) begin
                if (bus.i_r_e[r]) begin
                    r_data_r[r] <= rd_val_s[r];
                end
            end
        end
    end

    // Drive the bus outputs from the registers.
    always_comb begin
        for (int r = 0; r < R_PORTS; r++) begin
            bus.o_r_data[r] = r_data_r[r];
        end
        bus.o_ready = ready_r;
    end
endmodule
